// File: rtl/pb_keys_pkg.sv
// Shared key codes, sizing constants and debounce state type
// for the pushbutton key-entry front end.
package pb_keys_pkg;

    localparam int NUM_PB     = 21;
    localparam int DEB_CYCLES = 2;
    localparam int MAX_DIGITS = 8;
    localparam int KEY_W      = 5;

    localparam logic [KEY_W-1:0] KEY_ENTER = 5'd16;
    localparam logic [KEY_W-1:0] KEY_BKSP  = 5'd17;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 5'd18;
    localparam logic [KEY_W-1:0] KEY_OP    = 5'd19;
    localparam logic [KEY_W-1:0] KEY_RUN   = 5'd20;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WT,
        HELD,
        REL_WT
    } deb_state_t;

    function automatic logic is_hex(input logic [KEY_W-1:0] k);
        return !k[KEY_W-1];
    endfunction

endpackage

// File: rtl/pb_debouncer.sv
// Synchroniser, lowest-index priority encoder and debounce FSM;
// emits one registered strobe per debounced press.
module pb_debouncer
    import pb_keys_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic [NUM_PB-1:0] pb,
    output logic              key_strobe,
    output logic [KEY_W-1:0]  key_code
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

    logic [NUM_PB-1:0] sync1_q;
    logic [NUM_PB-1:0] sync2_q;
    deb_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [KEY_W-1:0]  cand_q;
    logic [KEY_W-1:0]  cand_code;
    logic              any_pressed;

    // Scan downwards so the lowest pressed index wins.
    always_comb begin
        cand_code = '0;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (sync2_q[i]) cand_code = KEY_W'(i);
        end
    end

    assign any_pressed = |sync2_q;
    assign cnt_inc     = cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            key_strobe <= 1'b0;
            key_code   <= '0;
        end else begin
            sync1_q    <= pb;
            sync2_q    <= sync1_q;
            key_strobe <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_pressed) begin
                        state_q <= PRESS_WT;
                        cand_q  <= cand_code;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESS_WT: begin
                    if (!any_pressed || cand_code != cand_q) begin
                        state_q <= IDLE;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_q    <= HELD;
                        key_strobe <= 1'b1;
                        key_code   <= cand_q;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!any_pressed) begin
                        state_q <= REL_WT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                REL_WT: begin
                    if (any_pressed) begin
                        state_q <= HELD;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pb_key_entry.sv
// Key-entry front end: debounced keys drive hex operand assembly,
// op/run requests and a valid/ready operand output.
module pb_key_entry
    import pb_keys_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic [NUM_PB-1:0] pb,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [31:0]       entry_value,
    output logic [3:0]        digit_count,
    output logic [1:0]        op_sel,
    output logic              run_pulse,
    output logic              key_strobe,
    output logic [KEY_W-1:0]  key_code
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    logic [31:0] entry_q, entry_d;
    logic [3:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  op_q, op_d;
    logic        run_q, run_d;
    logic        enter_ok;

    pb_debouncer u_deb (
        .clk        (clk),
        .nrst       (nrst),
        .pb         (pb),
        .key_strobe (key_strobe),
        .key_code   (key_code)
    );

    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        valid_d  = valid_q && !out_ready;
        data_d   = data_q;
        op_d     = op_q;
        run_d    = 1'b0;
        // A pending operand that is not being taken this cycle blocks ENTER.
        enter_ok = (count_q != 4'd0) && !(valid_q && !out_ready);
        if (key_strobe) begin
            unique case (1'b1)
                is_hex(key_code): begin
                    if (count_q < MAX_CNT) begin
                        entry_d = {entry_q[27:0], key_code[3:0]};
                        count_d = count_q + 4'd1;
                    end
                end
                key_code == KEY_BKSP: begin
                    if (count_q != 4'd0) begin
                        entry_d = entry_q >> 4;
                        count_d = count_q - 4'd1;
                    end
                end
                key_code == KEY_CLEAR: begin
                    entry_d = '0;
                    count_d = '0;
                end
                key_code == KEY_ENTER: begin
                    if (enter_ok) begin
                        data_d  = entry_q;
                        valid_d = 1'b1;
                        entry_d = '0;
                        count_d = '0;
                    end
                end
                key_code == KEY_OP:  op_d  = op_q + 2'd1;
                key_code == KEY_RUN: run_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            entry_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            run_q   <= run_d;
        end
    end

    assign entry_value = entry_q;
    assign digit_count = count_q;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign op_sel      = op_q;
    assign run_pulse   = run_q;

endmodule

// File: tb/tb_pb_key_entry.sv
// Self-checking bench for pb_key_entry: vector table, directed
// corner sequences and a randomized run against a key-level model.
module tb_pb_key_entry;

    logic        clk = 1'b0;
    logic        nrst;
    logic [20:0] pb;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] entry_value;
    logic [3:0]  digit_count;
    logic [1:0]  op_sel;
    logic        run_pulse;
    logic        key_strobe;
    logic [4:0]  key_code;

    pb_key_entry dut (
        .clk         (clk),
        .nrst        (nrst),
        .pb          (pb),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .entry_value (entry_value),
        .digit_count (digit_count),
        .op_sel      (op_sel),
        .run_pulse   (run_pulse),
        .key_strobe  (key_strobe),
        .key_code    (key_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int runs = 0;
    int last_strobe_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_strobe) begin
            strobes = strobes + 1;
            last_strobe_cyc = cyc;
        end
        if (run_pulse) runs = runs + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [20:0] m, input logic r,
                         input int hold);
        @(negedge clk);
        out_ready = r;
        pb = m;
        repeat (hold) @(negedge clk);
        pb = '0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        int          key;
        bit          rdy;
        logic [31:0] entry;
        logic [3:0]  cnt;
        bit          valid;
        logic [31:0] data;
        logic [1:0]  op;
    } vec_t;

    vec_t tbl[$];

    int mq[$];
    bit mvalid;
    logic [31:0] mdata;
    logic [1:0] mop;
    int mcode;
    int mstrobes;
    int mruns;

    function automatic logic [31:0] qval();
        logic [31:0] v = '0;
        foreach (mq[i]) v = v * 32'd16 + 32'(mq[i]);
        return v;
    endfunction

    initial begin
        int s0, r0, c0, k, k2, hold;
        bit r, two, seen, pend;
        logic [20:0] m;

        nrst = 1'b0;
        pb = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {out_valid, out_data, entry_value, digit_count, op_sel,
             run_pulse, key_strobe, key_code}, '0);
        nrst = 1'b1;
        repeat (3) @(negedge clk);

        // Long hold yields exactly one event.
        s0 = strobes;
        @(negedge clk);
        pb = 21'h8;
        c0 = cyc;
        repeat (20) @(negedge clk);
        pb = '0;
        repeat (8) @(negedge clk);
        chk("hold_one_strobe", strobes - s0, 1);
        chk("hold_latency", last_strobe_cyc - c0, 4);
        chk("hold_code", key_code, 3);
        chk("hold_entry", entry_value, 32'h3);
        chk("hold_count", digit_count, 1);

        // Bounce then steady press.
        s0 = strobes;
        @(negedge clk); pb = 21'h20;
        @(negedge clk); pb = '0;
        @(negedge clk); pb = 21'h20;
        @(negedge clk); pb = '0;
        @(negedge clk); pb = 21'h20;
        c0 = cyc;
        repeat (10) @(negedge clk);
        pb = '0;
        repeat (8) @(negedge clk);
        chk("bounce_one_strobe", strobes - s0, 1);
        chk("bounce_latency", last_strobe_cyc - c0, 4);
        chk("bounce_entry", entry_value, 32'h35);

        tbl.push_back('{18, 0, 32'h0,        4'd0, 0, 32'h0,  2'd0});
        tbl.push_back('{1,  0, 32'h1,        4'd1, 0, 32'h0,  2'd0});
        tbl.push_back('{2,  0, 32'h12,       4'd2, 0, 32'h0,  2'd0});
        tbl.push_back('{3,  0, 32'h123,      4'd3, 0, 32'h0,  2'd0});
        tbl.push_back('{4,  0, 32'h1234,     4'd4, 0, 32'h0,  2'd0});
        tbl.push_back('{5,  0, 32'h12345,    4'd5, 0, 32'h0,  2'd0});
        tbl.push_back('{6,  0, 32'h123456,   4'd6, 0, 32'h0,  2'd0});
        tbl.push_back('{7,  0, 32'h1234567,  4'd7, 0, 32'h0,  2'd0});
        tbl.push_back('{8,  0, 32'h12345678, 4'd8, 0, 32'h0,  2'd0});
        tbl.push_back('{9,  0, 32'h12345678, 4'd8, 0, 32'h0,  2'd0});
        tbl.push_back('{17, 0, 32'h01234567, 4'd7, 0, 32'h0,  2'd0});
        tbl.push_back('{18, 0, 32'h0,        4'd0, 0, 32'h0,  2'd0});
        tbl.push_back('{10, 0, 32'hA,        4'd1, 0, 32'h0,  2'd0});
        tbl.push_back('{11, 0, 32'hAB,       4'd2, 0, 32'h0,  2'd0});
        tbl.push_back('{16, 0, 32'h0,        4'd0, 1, 32'hAB, 2'd0});
        tbl.push_back('{12, 0, 32'hC,        4'd1, 1, 32'hAB, 2'd0});
        tbl.push_back('{16, 0, 32'hC,        4'd1, 1, 32'hAB, 2'd0});
        tbl.push_back('{17, 0, 32'h0,        4'd0, 1, 32'hAB, 2'd0});
        tbl.push_back('{17, 0, 32'h0,        4'd0, 1, 32'hAB, 2'd0});
        tbl.push_back('{16, 1, 32'h0,        4'd0, 0, 32'hAB, 2'd0});
        tbl.push_back('{19, 0, 32'h0,        4'd0, 0, 32'hAB, 2'd1});
        tbl.push_back('{19, 0, 32'h0,        4'd0, 0, 32'hAB, 2'd2});
        tbl.push_back('{19, 0, 32'h0,        4'd0, 0, 32'hAB, 2'd3});
        tbl.push_back('{19, 0, 32'h0,        4'd0, 0, 32'hAB, 2'd0});
        tbl.push_back('{19, 0, 32'h0,        4'd0, 0, 32'hAB, 2'd1});

        for (int i = 0; i < tbl.size(); i++) begin
            m = 21'd1 << tbl[i].key;
            press(m, tbl[i].rdy, 7);
            chk($sformatf("vec%0d_entry", i), entry_value, tbl[i].entry);
            chk($sformatf("vec%0d_count", i), digit_count, tbl[i].cnt);
            chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].valid);
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].data);
            chk($sformatf("vec%0d_op", i), op_sel, tbl[i].op);
        end

        r0 = runs;
        press(21'd1 << 20, 1'b0, 7);
        chk("run_single_pulse", runs - r0, 1);

        // Pending operand drops one cycle after ready rises.
        press(21'd1 << 4, 1'b0, 7);
        press(21'd1 << 16, 1'b0, 7);
        chk("pend_valid", out_valid, 1);
        chk("pend_data", out_data, 32'h4);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_next_cycle", out_valid, 0);
        out_ready = 1'b0;

        // ENTER accepted in the same cycle the old operand is taken.
        press(21'd1 << 9, 1'b0, 7);
        press(21'd1 << 16, 1'b0, 7);
        chk("pend9_data", out_data, 32'h9);
        press(21'd1 << 7, 1'b0, 7);
        @(negedge clk);
        pb = 21'd1 << 16;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (key_strobe) begin
                seen = 1'b1;
                break;
            end
        end
        chk("enter_strobe_seen", seen, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("reload_valid", out_valid, 1);
        chk("reload_data", out_data, 32'h7);
        chk("reload_entry", {entry_value, digit_count}, '0);
        @(negedge clk);
        chk("reload_stable", {out_valid, out_data}, {1'b1, 32'h7});
        pb = '0;
        repeat (8) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a press.
        press(21'd1 << 5, 1'b0, 7);
        chk("pre_reset_op", op_sel, 1);
        @(negedge clk);
        pb = 21'd1 << 2;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("midpress_reset",
            {out_valid, out_data, entry_value, digit_count, op_sel,
             run_pulse, key_strobe, key_code}, '0);
        @(negedge clk);
        nrst = 1'b1;
        s0 = strobes;
        repeat (10) @(negedge clk);
        chk("post_reset_strobe", strobes - s0, 1);
        chk("post_reset_code", key_code, 2);
        chk("post_reset_entry", {entry_value, digit_count},
            {32'h2, 4'd1});
        pb = '0;
        repeat (8) @(negedge clk);

        mq = '{2};
        mvalid = 1'b0;
        mdata = '0;
        mop = '0;
        mcode = 2;
        mstrobes = strobes;
        mruns = runs;

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 0) k = $urandom_range(0, 15);
            else k = $urandom_range(16, 20);
            r = 1'($urandom_range(0, 1));
            two = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(6, 12);
            m = 21'd1 << k;
            if (two) begin
                k2 = $urandom_range(k, 20);
                m = m | (21'd1 << k2);
            end

            pend = mvalid && !r;
            mcode = k;
            mstrobes++;
            if (k < 16) begin
                if (mq.size() < 8) mq.push_back(k);
            end else if (k == 16) begin
                if (mq.size() > 0 && !pend) begin
                    mdata = qval();
                    mvalid = 1'b1;
                    mq.delete();
                end
            end else if (k == 17) begin
                if (mq.size() > 0) void'(mq.pop_back());
            end else if (k == 18) begin
                mq.delete();
            end else if (k == 19) begin
                mop = mop + 2'd1;
            end else begin
                mruns++;
            end
            if (r) mvalid = 1'b0;

            press(m, r, hold);
            chk($sformatf("rnd%0d_entry", n), entry_value, qval());
            chk($sformatf("rnd%0d_count", n), digit_count, mq.size());
            chk($sformatf("rnd%0d_valid", n), out_valid, mvalid);
            chk($sformatf("rnd%0d_data", n), out_data, mdata);
            chk($sformatf("rnd%0d_op", n), op_sel, mop);
            chk($sformatf("rnd%0d_code", n), key_code, mcode);
            chk($sformatf("rnd%0d_strobes", n), strobes, mstrobes);
            chk($sformatf("rnd%0d_runs", n), runs, mruns);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
